// File: rtl/output_queue_schedule.sv
// Strict-priority dequeue scheduler for eight output queues. Holds one request
// until it is acked or withdrawn, then waits for transmit-done under a watchdog.
module output_queue_schedule #(
  parameter logic [11:0] WATCHDOG_CYCLES = 12'd4095
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  iv_out_gate_ctrl_vector,
  input  logic [7:0]  iv_queue_empty,
  output logic        o_schedule_valid,
  output logic [2:0]  ov_schedule_queue_id,
  input  logic        i_schedule_ack,
  input  logic        i_transmit_done,
  output logic        o_timeout_err,
  output logic [15:0] ov_sched_cnt,
  output logic [7:0]  ov_timeout_cnt
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_DONE} state_e;

  state_e      state_q, state_d;
  logic [2:0]  queue_id_q, queue_id_d;
  logic [11:0] wd_q, wd_d;
  logic        timeout_err_q, timeout_err_d;
  logic [15:0] sched_cnt_q, sched_cnt_d;
  logic [7:0]  timeout_cnt_q, timeout_cnt_d;

  logic [7:0]  eligible;
  logic [2:0]  top_id;
  logic        sel_blocked;
  logic        wd_expired;

  // Ascending scan so the last hit is the highest eligible index.
  always_comb begin
    eligible = iv_out_gate_ctrl_vector & ~iv_queue_empty;
    top_id   = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (eligible[i]) top_id = 3'(i);
    end
    sel_blocked = !iv_out_gate_ctrl_vector[queue_id_q] || iv_queue_empty[queue_id_q];
    wd_expired  = (wd_q == WATCHDOG_CYCLES);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (|eligible) state_d = REQ;
      REQ: begin
        if (i_schedule_ack)   state_d = WAIT_DONE;
        else if (sel_blocked) state_d = IDLE;
      end
      WAIT_DONE: if (i_transmit_done || wd_expired) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Transmit-done takes priority over watchdog expiry in the same cycle.
  always_comb begin
    queue_id_d    = queue_id_q;
    wd_d          = wd_q;
    timeout_err_d = 1'b0;
    sched_cnt_d   = sched_cnt_q;
    timeout_cnt_d = timeout_cnt_q;
    case (state_q)
      IDLE: if (|eligible) queue_id_d = top_id;
      REQ: begin
        if (i_schedule_ack) begin
          sched_cnt_d = sched_cnt_q + 16'd1;
          wd_d        = '0;
        end
      end
      WAIT_DONE: begin
        if (!i_transmit_done && wd_expired) begin
          timeout_err_d = 1'b1;
          if (timeout_cnt_q != '1) timeout_cnt_d = timeout_cnt_q + 8'd1;
        end else begin
          wd_d = wd_q + 12'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      queue_id_q    <= '0;
      wd_q          <= '0;
      timeout_err_q <= 1'b0;
      sched_cnt_q   <= '0;
      timeout_cnt_q <= '0;
    end else begin
      queue_id_q    <= queue_id_d;
      wd_q          <= wd_d;
      timeout_err_q <= timeout_err_d;
      sched_cnt_q   <= sched_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
    end
  end

  assign o_schedule_valid     = (state_q == REQ);
  assign ov_schedule_queue_id = queue_id_q;
  assign o_timeout_err        = timeout_err_q;
  assign ov_sched_cnt         = sched_cnt_q;
  assign ov_timeout_cnt       = timeout_cnt_q;

endmodule

// File: tb/tb_output_queue_schedule.sv
// Randomized and directed bench for output_queue_schedule, checked every cycle
// against a transaction-level reference model.
module tb_output_queue_schedule;

  localparam int WD = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  gate = '0;
  logic [7:0]  empty = '1;
  logic        ack = 1'b0;
  logic        done = 1'b0;
  logic        valid;
  logic [2:0]  qid;
  logic        terr;
  logic [15:0] sched_cnt;
  logic [7:0]  tout_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: outstanding request, frame in flight with its age, counters.
  bit m_pending = 0;
  bit m_busy = 0;
  int m_age = 0;
  int m_id = 0;
  int m_sched = 0;
  int m_tout = 0;
  bit m_terr = 0;

  always #4 clk = ~clk;

  output_queue_schedule #(.WATCHDOG_CYCLES(12'd10)) dut (
    .i_clk                   (clk),
    .i_rst_n                 (rst_n),
    .iv_out_gate_ctrl_vector (gate),
    .iv_queue_empty          (empty),
    .o_schedule_valid        (valid),
    .ov_schedule_queue_id    (qid),
    .i_schedule_ack          (ack),
    .i_transmit_done         (done),
    .o_timeout_err           (terr),
    .ov_sched_cnt            (sched_cnt),
    .ov_timeout_cnt          (tout_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic int highest(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_step(input logic r, input logic [7:0] g, input logic [7:0] e,
                            input logic a, input logic d);
    m_terr = 0;
    if (!r) begin
      m_pending = 0; m_busy = 0; m_age = 0; m_id = 0; m_sched = 0; m_tout = 0;
    end else if (m_pending) begin
      if (a) begin
        m_sched = (m_sched + 1) % 65536;
        m_pending = 0; m_busy = 1; m_age = 0;
      end else if (!g[m_id] || e[m_id]) begin
        m_pending = 0;
      end
    end else if (m_busy) begin
      if (d) m_busy = 0;
      else if (m_age == WD) begin
        m_busy = 0; m_terr = 1;
        if (m_tout < 255) m_tout++;
      end else m_age++;
    end else if (highest(g & ~e) >= 0) begin
      m_id = highest(g & ~e);
      m_pending = 1;
    end
  endtask

  task automatic cycle(input logic r, input logic [7:0] g, input logic [7:0] e,
                       input logic a, input logic d);
    @(negedge clk);
    check_eq("valid", {31'd0, valid}, {31'd0, m_pending});
    check_eq("queue_id", {29'd0, qid}, m_id);
    check_eq("timeout_err", {31'd0, terr}, {31'd0, m_terr});
    check_eq("sched_cnt", {16'd0, sched_cnt}, m_sched);
    check_eq("timeout_cnt", {24'd0, tout_cnt}, m_tout);
    rst_n = r; gate = g; empty = e; ack = a; done = d;
    model_step(r, g, e, a, d);
  endtask

  initial begin
    // reset
    cycle(0, 8'h00, 8'hFF, 0, 0);
    cycle(0, 8'hFF, 8'h00, 1, 1);
    cycle(1, 8'h00, 8'h00, 0, 0);

    // basic request/ack/done, plus request holding stable without ack
    cycle(1, 8'hFF, 8'b0101_1111, 0, 0);
    cycle(1, 8'hFF, 8'b0101_1111, 0, 0);
    cycle(1, 8'hFF, 8'b0101_1111, 0, 0);
    cycle(1, 8'hFF, 8'b0101_1111, 1, 0);
    cycle(1, 8'hFF, 8'b0101_1111, 0, 0);
    cycle(1, 8'h00, 8'hFF, 0, 1);
    cycle(1, 8'h00, 8'hFF, 0, 0);

    // only low gates open
    cycle(1, 8'h03, 8'h00, 0, 0);
    cycle(1, 8'h03, 8'h00, 1, 0);
    cycle(1, 8'h03, 8'h00, 0, 1);
    cycle(1, 8'h00, 8'h00, 0, 0);

    // withdraw, no preemption, ack beats gate close
    cycle(1, 8'h40, 8'h00, 0, 0);
    cycle(1, 8'hC0, 8'h00, 0, 0);
    cycle(1, 8'h80, 8'h00, 0, 0);
    cycle(1, 8'h00, 8'h00, 0, 0);
    cycle(1, 8'h40, 8'h00, 0, 0);
    cycle(1, 8'h00, 8'h00, 1, 0);
    cycle(1, 8'h00, 8'h00, 0, 0);
    cycle(1, 8'h00, 8'h00, 0, 1);
    cycle(1, 8'h00, 8'h00, 0, 1);

    // watchdog expiry, then done on the expiry cycle
    cycle(1, 8'h01, 8'h00, 0, 0);
    cycle(1, 8'h01, 8'h00, 1, 0);
    for (int i = 0; i < 14; i++) cycle(1, 8'h00, 8'h00, 1, 0);
    cycle(1, 8'h01, 8'h00, 0, 0);
    cycle(1, 8'h01, 8'h00, 1, 0);
    for (int i = 0; i < WD; i++) cycle(1, 8'h00, 8'h00, 0, 0);
    cycle(1, 8'h00, 8'h00, 0, 1);
    cycle(1, 8'h00, 8'h00, 0, 0);
    cycle(1, 8'h00, 8'h00, 0, 0);

    // reset mid-transfer, then a fresh request
    cycle(1, 8'h08, 8'h00, 0, 0);
    cycle(1, 8'h08, 8'h00, 1, 0);
    cycle(1, 8'h08, 8'h00, 0, 0);
    cycle(0, 8'h08, 8'h00, 0, 0);
    cycle(1, 8'h08, 8'h00, 0, 0);
    cycle(1, 8'h08, 8'h00, 0, 0);
    cycle(1, 8'h08, 8'h00, 1, 0);
    cycle(1, 8'h00, 8'h00, 0, 1);
    cycle(1, 8'h00, 8'h00, 0, 0);

    // accepted-request counter wrap from a preloaded value
    force dut.sched_cnt_q = 16'hFFFF;
    m_sched = 16'hFFFF;
    cycle(1, 8'h00, 8'h00, 0, 0);
    release dut.sched_cnt_q;
    cycle(1, 8'h00, 8'h00, 0, 0);
    cycle(1, 8'h20, 8'h00, 0, 0);
    cycle(1, 8'h20, 8'h00, 1, 0);
    cycle(1, 8'h20, 8'h00, 0, 1);
    cycle(1, 8'h00, 8'h00, 0, 0);

    // timeout counter saturation
    for (int i = 0; i < 300 * (WD + 3); i++) cycle(1, 8'hFF, 8'h00, 1, 0);
    cycle(1, 8'h00, 8'h00, 0, 1);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      logic r;
      logic [7:0] g, e;
      r = ($urandom_range(0, 199) != 0);
      g = 8'($urandom) | 8'($urandom);
      e = 8'($urandom) & 8'($urandom);
      cycle(r, g, e, ($urandom_range(0, 1) == 1), ($urandom_range(0, 9) == 0));
    end
    cycle(1, 8'h00, 8'h00, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
